multicycle_control_gen: RTL and testbench
=========================================

Name: multicycle_control_gen

Overview:
- Parametrised multicycle RISC-V (RV32I subset) control FSM.
- Adds variable memory wait-states, either a fixed counter or a mem_ready handshake.
- Adds LUI/AUIPC, illegal-opcode trap and a one-cycle retire strobe.
- Sits between the instruction register and the multicycle datapath; datapath holds the fetched instruction's PC in OldPC.

Parameters:
- MEM_WAIT, 2: wait cycles added to every memory access in counter mode (0..15).
- USE_MEM_READY, 0: 0 = fixed counter; 1 = access ends on mem_ready.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12]; passed to ALU control only.
- zero_flag  in  1  ALU zero, used by datapath branch gating.
- mem_ready  in  1  memory done; ignored when USE_MEM_READY=0.
- estadoAtual  out  5  current state encoding.
- proximoEstado  out  5  combinational next state.
- MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg, IorD, ALUSrcB, Jump, Jalr  out  1 each  datapath strobes.
- ALUSrcA  out  2  00 rs1, 01 OldPC, 10 zero.
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type.
- PCSource  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR result.
- illegal_instr  out  1  sticky trap flag.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset (reset=0, async):
  - State goes to FETCH and the wait counter to 0.
  - Every strobe, illegal_instr and retire are forced 0 while reset is low.
  - Reset mid-access abandons the access; first fetch begins on the first clock after release.
- Outputs are Moore-decoded from state. Exception: IRWrite/PCWrite/retire on wait-state exit, which also depend on done.
- Wait counter, counter mode:
  - Loaded with MEM_WAIT on entry to FETCH_WAIT or MEM_ACCESS, decremented each cycle.
  - done = (cnt==0), so the wait state lasts exactly MEM_WAIT+1 cycles.
- Handshake mode: done = mem_ready sampled in the wait state. If mem_ready is already high on the first cycle, the state lasts 1 cycle; no timeout.
- FETCH, 1 cycle: MemRead=1, IorD=0. Next state is FETCH_WAIT.
- FETCH_WAIT:
  - MemRead=1 held throughout.
  - On the done cycle: IRWrite=1, PCWrite=1, PCSource=00, next DECODE. Otherwise remain.
- DECODE, 1 cycle, dispatch on opcode:
  - 0110011 → EX_R; 0010011 → EX_I.
  - 0000011 / 0100011 → MEM_ADDR.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - 0110111 → EX_LUI; 0010111 → EX_AUIPC.
  - Any other opcode → TRAP.
- EX_R: ALUSrcA=00, ALUSrcB=0, ALUOp=10, next ALU_WB.
- EX_I: ALUSrcA=00, ALUSrcB=1, ALUOp=11, next ALU_WB.
- EX_LUI: ALUSrcA=10, ALUSrcB=1, ALUOp=00, next ALU_WB.
- EX_AUIPC: ALUSrcA=01, ALUSrcB=1, ALUOp=00, next ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, retire=1, next FETCH.
- MEM_ADDR: ALUSrcB=1, ALUOp=00, next MEM_ACCESS.
- MEM_ACCESS:
  - IorD=1; MemRead (load) or MemWrite (store) held every cycle.
  - On done, a load goes to LOAD_WB.
  - On done, a store asserts retire=1 and goes to FETCH.
- LOAD_WB: RegWrite=1, MemtoReg=1, retire=1, next FETCH.
- BRANCH: ALUOp=01, PCWriteCond=1, PCSource=01, retire=1, next FETCH.
- JAL: Jump=1, RegWrite=1, PCWrite=1, PCSource=10, retire=1, next FETCH.
- JALR: Jalr=1, RegWrite=1, ALUSrcB=1, ALUOp=00, PCWrite=1, PCSource=11, retire=1, next FETCH.
- TRAP: illegal_instr=1, all strobes 0. The FSM stays in TRAP until reset.
- opcode must stay stable from DECODE to instruction end; IR is written only in FETCH_WAIT.

Optional Feature:
- Macro: CTRL_INSTRET_EN.
- Defined:
  - Adds output instret [31:0], reset to 0.
  - Increments on every retire pulse and wraps 0xFFFFFFFF→0.
  - Never increments in TRAP.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg: state enum (5-bit), RV32I opcode constants, ALUOp, ALUSrcA and PCSource encodings.
- Sub-module mem_wait_timer: holds the load/decrement counter and the mode mux, and produces done.

Test Plan:
- MEM_WAIT=2, counter mode, add (0x33): FETCH, FETCH_WAIT ×3 (IRWrite/PCWrite on the 3rd), DECODE, EX_R, ALU_WB with RegWrite=1 and retire=1. Total 7 cycles.
- USE_MEM_READY=1, lw with mem_ready low for 4 cycles then high: MemRead and IorD=1 held for 5 MEM_ACCESS cycles, then LOAD_WB with MemtoReg=1 and RegWrite=1.
- sw with MEM_WAIT=0: MEM_ACCESS lasts 1 cycle with MemWrite=1 and retire=1, then FETCH.
- opcode 0x00 in DECODE: TRAP, illegal_instr=1 held for 20 cycles with MemRead=0; reset low then high returns to FETCH with illegal_instr=0.
- reset asserted in cycle 2 of a MEM_ACCESS store: MemWrite drops immediately, state becomes FETCH, no retire pulse.
- With CTRL_INSTRET_EN, run lui, auipc, jal, jalr, beq: EX_LUI asserts ALUSrcA=10, EX_AUIPC asserts ALUSrcA=01, and instret = 5 after the beq retires.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control slice: FSM state
// encoding, opcode constants, datapath mux encodings, the control strobe
// bundle and the opcode dispatch helper.
package ctrl_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_FETCH_WAIT = 5'd1,
        S_DECODE     = 5'd2,
        S_EX_R       = 5'd3,
        S_EX_I       = 5'd4,
        S_EX_LUI     = 5'd5,
        S_EX_AUIPC   = 5'd6,
        S_ALU_WB     = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_MEM_ACCESS = 5'd9,
        S_LOAD_WB    = 5'd10,
        S_BRANCH     = 5'd11,
        S_JAL        = 5'd12,
        S_JALR       = 5'd13,
        S_TRAP       = 5'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_RS1   = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_ZERO  = 2'b10;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JAL    = 2'b10;
    localparam logic [1:0] PCSRC_JALR   = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       ior_d;
        logic       alu_src_b;
        logic       jump;
        logic       jalr;
        logic [1:0] alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_instr;
        logic       retire;
    } ctrl_t;

    // Map an opcode to the first execute-phase state; unknown opcodes trap.
    function automatic state_t decode_opcode(input logic [6:0] op);
        state_t s;
        case (op)
            OP_R:               s = S_EX_R;
            OP_I:               s = S_EX_I;
            OP_LOAD, OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            OP_JAL:             s = S_JAL;
            OP_JALR:            s = S_JALR;
            OP_LUI:             s = S_EX_LUI;
            OP_AUIPC:           s = S_EX_AUIPC;
            default:            s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer. In counter mode the count is loaded with
// MEM_WAIT when a wait state is entered and counts down to zero, so the
// wait state lasts MEM_WAIT+1 cycles. In handshake mode done follows
// mem_ready directly.
module mem_wait_timer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT      = 2,
    parameter int USE_MEM_READY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic active,
    input  logic mem_ready,
    output logic done
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Load on wait-state entry, count down while waiting, hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = WAIT_CNT_W'(MEM_WAIT);
        end else if (active && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
    end

    // Counter register; reset abandons any access in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Mode mux: handshake takes mem_ready, counter mode ends at zero.
    always_comb begin
        done = (USE_MEM_READY != 0) ? mem_ready : (cnt_q == '0);
    end

endmodule

// File: rtl/multicycle_control_gen.sv
// Multicycle RV32I-subset control FSM with memory wait states, LUI/AUIPC,
// illegal-opcode trap and a one-cycle retire strobe.
// Optional build macro CTRL_INSTRET_EN adds a 32-bit retired-instruction
// counter on output instret.
module multicycle_control_gen
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT      = 2,
    parameter int USE_MEM_READY = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic [4:0] estadoAtual,
    output logic [4:0] proximoEstado,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       IorD,
    output logic       ALUSrcB,
    output logic       Jump,
    output logic       Jalr,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_instr,
    output logic       retire
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    state_t state_q;
    state_t state_d;
    logic   done;
    logic   is_store;
    logic   timer_load;
    logic   timer_active;
    ctrl_t  ctl;
    ctrl_t  ctl_out;

    // funct3 goes to ALU control and zero_flag to branch gating in the
    // datapath; neither steers the sequencing here.
    logic unused_inputs;
    assign unused_inputs = ^{funct3, zero_flag};

    assign is_store     = (opcode == OP_STORE);
    assign timer_load   = (state_q == S_FETCH) || (state_q == S_MEM_ADDR);
    assign timer_active = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_ACCESS);

    mem_wait_timer #(
        .MEM_WAIT      (MEM_WAIT),
        .USE_MEM_READY (USE_MEM_READY)
    ) u_mem_wait_timer (
        .clk       (clock),
        .rst_n     (reset),
        .load      (timer_load),
        .active    (timer_active),
        .mem_ready (mem_ready),
        .done      (done)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (done) state_d = S_DECODE;
            S_DECODE:     state_d = decode_opcode(opcode);
            S_EX_R,
            S_EX_I,
            S_EX_LUI,
            S_EX_AUIPC:   state_d = S_ALU_WB;
            S_MEM_ADDR:   state_d = S_MEM_ACCESS;
            S_MEM_ACCESS: if (done) state_d = is_store ? S_FETCH : S_LOAD_WB;
            S_ALU_WB,
            S_LOAD_WB,
            S_BRANCH,
            S_JAL,
            S_JALR:       state_d = S_FETCH;
            S_TRAP:       state_d = S_TRAP;
            default:      state_d = S_FETCH;
        endcase
    end

    // State register; async reset returns to FETCH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of strobes; wait-state exits additionally use done.
    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
            end
            S_FETCH_WAIT: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = done;
                ctl.pc_write  = done;
                ctl.pc_source = PCSRC_PC4;
            end
            S_EX_R: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_op    = ALUOP_RTYPE;
            end
            S_EX_I: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALUOP_ITYPE;
            end
            S_EX_LUI: begin
                ctl.alu_src_a = SRCA_ZERO;
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_EX_AUIPC: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_ALU_WB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ACCESS: begin
                ctl.ior_d     = 1'b1;
                ctl.mem_read  = !is_store;
                ctl.mem_write = is_store;
                ctl.retire    = is_store && done;
            end
            S_LOAD_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_op        = ALUOP_BRANCH;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_BRANCH;
                ctl.retire        = 1'b1;
            end
            S_JAL: begin
                ctl.jump      = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JAL;
                ctl.retire    = 1'b1;
            end
            S_JALR: begin
                ctl.jalr      = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JALR;
                ctl.retire    = 1'b1;
            end
            S_TRAP: begin
                ctl.illegal_instr = 1'b1;
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

    // Everything is silenced while reset is held low.
    assign ctl_out = reset ? ctl : '0;

    assign estadoAtual   = state_q;
    assign proximoEstado = state_d;
    assign MemRead       = ctl_out.mem_read;
    assign MemWrite      = ctl_out.mem_write;
    assign IRWrite       = ctl_out.ir_write;
    assign PCWrite       = ctl_out.pc_write;
    assign PCWriteCond   = ctl_out.pc_write_cond;
    assign RegWrite      = ctl_out.reg_write;
    assign MemtoReg      = ctl_out.mem_to_reg;
    assign IorD          = ctl_out.ior_d;
    assign ALUSrcB       = ctl_out.alu_src_b;
    assign Jump          = ctl_out.jump;
    assign Jalr          = ctl_out.jalr;
    assign ALUSrcA       = ctl_out.alu_src_a;
    assign ALUOp         = ctl_out.alu_op;
    assign PCSource      = ctl_out.pc_source;
    assign illegal_instr = ctl_out.illegal_instr;
    assign retire        = ctl_out.retire;

`ifdef CTRL_INSTRET_EN
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    // Count retired instructions; wraps naturally at 2^32.
    always_comb begin
        instret_d = instret_q;
        if (ctl_out.retire && (state_q != S_TRAP)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_gen.sv
// Directed bench for multicycle_control_gen. Three instances:
//   0: MEM_WAIT=2, counter mode
//   1: MEM_WAIT=2, mem_ready handshake
//   2: MEM_WAIT=0, counter mode
module tb_multicycle_control_gen;
    import ctrl_pkg::*;

    logic clk;
    int   checks;
    int   failures;

    logic       rst_n   [3];
    logic [6:0] opc     [3];
    logic       mrdy    [3];
    logic [4:0] est     [3];
    logic [4:0] pst     [3];
    logic       o_mem_read  [3];
    logic       o_mem_write [3];
    logic       o_ir_write  [3];
    logic       o_pc_write  [3];
    logic       o_pc_wcond  [3];
    logic       o_reg_write [3];
    logic       o_mem_to_reg[3];
    logic       o_ior_d     [3];
    logic       o_src_b     [3];
    logic       o_jump      [3];
    logic       o_jalr      [3];
    logic [1:0] o_src_a     [3];
    logic [1:0] o_alu_op    [3];
    logic [1:0] o_pc_src    [3];
    logic       o_illegal   [3];
    logic       o_retire    [3];
`ifdef CTRL_INSTRET_EN
    logic [31:0] o_instret  [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        multicycle_control_gen #(
            .MEM_WAIT      ((g == 2) ? 0 : 2),
            .USE_MEM_READY ((g == 1) ? 1 : 0)
        ) u_dut (
            .clock         (clk),
            .reset         (rst_n[g]),
            .opcode        (opc[g]),
            .funct3        (3'b000),
            .zero_flag     (1'b0),
            .mem_ready     (mrdy[g]),
            .estadoAtual   (est[g]),
            .proximoEstado (pst[g]),
            .MemRead       (o_mem_read[g]),
            .MemWrite      (o_mem_write[g]),
            .IRWrite       (o_ir_write[g]),
            .PCWrite       (o_pc_write[g]),
            .PCWriteCond   (o_pc_wcond[g]),
            .RegWrite      (o_reg_write[g]),
            .MemtoReg      (o_mem_to_reg[g]),
            .IorD          (o_ior_d[g]),
            .ALUSrcB       (o_src_b[g]),
            .Jump          (o_jump[g]),
            .Jalr          (o_jalr[g]),
            .ALUSrcA       (o_src_a[g]),
            .ALUOp         (o_alu_op[g]),
            .PCSource      (o_pc_src[g]),
            .illegal_instr (o_illegal[g]),
            .retire        (o_retire[g])
`ifdef CTRL_INSTRET_EN
            ,
            .instret       (o_instret[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] seq_op   [5];
    state_t     seq_st   [5];

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            opc[i]   = 7'h00;
            mrdy[i]  = 1'b0;
        end
        seq_op = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
        seq_st = '{S_EX_LUI, S_EX_AUIPC, S_JAL, S_JALR, S_BRANCH};

        // Reset state on all instances
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_state",   32'(est[i]),        32'(S_FETCH));
            check("rst_memread", 32'(o_mem_read[i]), 32'd0);
            check("rst_retire",  32'(o_retire[i]),   32'd0);
            check("rst_illegal", 32'(o_illegal[i]),  32'd0);
`ifdef CTRL_INSTRET_EN
            check("rst_instret", o_instret[i],       32'd0);
`endif
        end

        // add with MEM_WAIT=2: 7-cycle instruction
        rst_n[0] = 1'b1;
        opc[0]   = 7'h33;
        #1;
        check("add_fetch_st",  32'(est[0]),        32'(S_FETCH));
        check("add_fetch_mr",  32'(o_mem_read[0]), 32'd1);
        check("add_fetch_iord",32'(o_ior_d[0]),    32'd0);
        tick();
        check("add_fw1_st",    32'(est[0]),        32'(S_FETCH_WAIT));
        check("add_fw1_mr",    32'(o_mem_read[0]), 32'd1);
        check("add_fw1_irw",   32'(o_ir_write[0]), 32'd0);
        tick();
        check("add_fw2_st",    32'(est[0]),        32'(S_FETCH_WAIT));
        check("add_fw2_irw",   32'(o_ir_write[0]), 32'd0);
        tick();
        check("add_fw3_st",    32'(est[0]),        32'(S_FETCH_WAIT));
        check("add_fw3_irw",   32'(o_ir_write[0]), 32'd1);
        check("add_fw3_pcw",   32'(o_pc_write[0]), 32'd1);
        check("add_fw3_pcs",   32'(o_pc_src[0]),   32'd0);
        check("add_fw3_next",  32'(pst[0]),        32'(S_DECODE));
        tick();
        check("add_dec_st",    32'(est[0]),        32'(S_DECODE));
        check("add_dec_next",  32'(pst[0]),        32'(S_EX_R));
        tick();
        check("add_exr_st",    32'(est[0]),        32'(S_EX_R));
        check("add_exr_op",    32'(o_alu_op[0]),   32'd2);
        check("add_exr_srcb",  32'(o_src_b[0]),    32'd0);
        check("add_exr_srca",  32'(o_src_a[0]),    32'd0);
        tick();
        check("add_wb_st",     32'(est[0]),        32'(S_ALU_WB));
        check("add_wb_rw",     32'(o_reg_write[0]),32'd1);
        check("add_wb_m2r",    32'(o_mem_to_reg[0]),32'd0);
        check("add_wb_ret",    32'(o_retire[0]),   32'd1);
        tick();
        check("add_end_st",    32'(est[0]),        32'(S_FETCH));
        check("add_end_ret",   32'(o_retire[0]),   32'd0);
`ifdef CTRL_INSTRET_EN
        check("add_instret",   o_instret[0],       32'd1);
`endif

        // sw on instance 0, reset in the 2nd MEM_ACCESS cycle
        opc[0] = 7'h23;
        repeat (4) tick();
        check("swr_dec_st",    32'(est[0]),        32'(S_DECODE));
        tick();
        check("swr_addr_st",   32'(est[0]),        32'(S_MEM_ADDR));
        check("swr_addr_srcb", 32'(o_src_b[0]),    32'd1);
        tick();
        check("swr_acc1_st",   32'(est[0]),        32'(S_MEM_ACCESS));
        check("swr_acc1_mw",   32'(o_mem_write[0]),32'd1);
        check("swr_acc1_mr",   32'(o_mem_read[0]), 32'd0);
        check("swr_acc1_iord", 32'(o_ior_d[0]),    32'd1);
        check("swr_acc1_ret",  32'(o_retire[0]),   32'd0);
        tick();
        check("swr_acc2_mw",   32'(o_mem_write[0]),32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("swr_rst_mw",    32'(o_mem_write[0]),32'd0);
        check("swr_rst_st",    32'(est[0]),        32'(S_FETCH));
        check("swr_rst_ret",   32'(o_retire[0]),   32'd0);
        tick();
        check("swr_rst2_ret",  32'(o_retire[0]),   32'd0);
        check("swr_rst2_st",   32'(est[0]),        32'(S_FETCH));
`ifdef CTRL_INSTRET_EN
        check("swr_instret",   o_instret[0],       32'd0);
`endif

        // lui, auipc, jal, jalr, beq on instance 0
        rst_n[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            opc[0] = seq_op[i];
            repeat (4) tick();
            check("seq_dec_st",  32'(est[0]),      32'(S_DECODE));
            tick();
            check("seq_exec_st", 32'(est[0]),      32'(seq_st[i]));
            case (i)
                0: begin
                    check("lui_srca",   32'(o_src_a[0]),  32'd2);
                    check("lui_srcb",   32'(o_src_b[0]),  32'd1);
                    check("lui_op",     32'(o_alu_op[0]), 32'd0);
                end
                1: begin
                    check("auipc_srca", 32'(o_src_a[0]),  32'd1);
                    check("auipc_srcb", 32'(o_src_b[0]),  32'd1);
                end
                2: begin
                    check("jal_jump",   32'(o_jump[0]),      32'd1);
                    check("jal_rw",     32'(o_reg_write[0]), 32'd1);
                    check("jal_pcw",    32'(o_pc_write[0]),  32'd1);
                    check("jal_pcs",    32'(o_pc_src[0]),    32'd2);
                    check("jal_ret",    32'(o_retire[0]),    32'd1);
                end
                3: begin
                    check("jalr_jalr",  32'(o_jalr[0]),      32'd1);
                    check("jalr_srcb",  32'(o_src_b[0]),     32'd1);
                    check("jalr_pcw",   32'(o_pc_write[0]),  32'd1);
                    check("jalr_pcs",   32'(o_pc_src[0]),    32'd3);
                    check("jalr_ret",   32'(o_retire[0]),    32'd1);
                end
                default: begin
                    check("beq_op",     32'(o_alu_op[0]),    32'd1);
                    check("beq_pwc",    32'(o_pc_wcond[0]),  32'd1);
                    check("beq_pcw",    32'(o_pc_write[0]),  32'd0);
                    check("beq_pcs",    32'(o_pc_src[0]),    32'd1);
                    check("beq_ret",    32'(o_retire[0]),    32'd1);
                end
            endcase
            if (i < 2) begin
                tick();
                check("seq_wb_st",  32'(est[0]),      32'(S_ALU_WB));
                check("seq_wb_ret", 32'(o_retire[0]), 32'd1);
            end
            tick();
            check("seq_end_st",  32'(est[0]),      32'(S_FETCH));
        end
`ifdef CTRL_INSTRET_EN
        check("seq_instret",   o_instret[0],       32'd5);
`endif

        // lw with mem_ready handshake on instance 1
        rst_n[1] = 1'b1;
        opc[1]   = 7'h03;
        tick();
        check("lw_fw1_st",     32'(est[1]),        32'(S_FETCH_WAIT));
        check("lw_fw1_irw",    32'(o_ir_write[1]), 32'd0);
        tick();
        check("lw_fw2_st",     32'(est[1]),        32'(S_FETCH_WAIT));
        mrdy[1] = 1'b1;
        #1;
        check("lw_fw2_irw",    32'(o_ir_write[1]), 32'd1);
        tick();
        mrdy[1] = 1'b0;
        check("lw_dec_next",   32'(pst[1]),        32'(S_MEM_ADDR));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            mrdy[1] = (i == 4);
            #1;
            check("lw_acc_st",   32'(est[1]),        32'(S_MEM_ACCESS));
            check("lw_acc_mr",   32'(o_mem_read[1]), 32'd1);
            check("lw_acc_iord", 32'(o_ior_d[1]),    32'd1);
            check("lw_acc_next", 32'(pst[1]),        (i == 4) ? 32'(S_LOAD_WB) : 32'(S_MEM_ACCESS));
            if (i < 4) tick();
        end
        tick();
        mrdy[1] = 1'b0;
        check("lw_wb_st",      32'(est[1]),          32'(S_LOAD_WB));
        check("lw_wb_m2r",     32'(o_mem_to_reg[1]), 32'd1);
        check("lw_wb_rw",      32'(o_reg_write[1]),  32'd1);
        check("lw_wb_ret",     32'(o_retire[1]),     32'd1);
        check("lw_wb_mr",      32'(o_mem_read[1]),   32'd0);

        // sw with MEM_WAIT=0 on instance 2
        rst_n[2] = 1'b1;
        opc[2]   = 7'h23;
        #1;
        check("sw0_fetch_st",  32'(est[2]),        32'(S_FETCH));
        tick();
        check("sw0_fw_irw",    32'(o_ir_write[2]), 32'd1);
        tick();
        check("sw0_dec_st",    32'(est[2]),        32'(S_DECODE));
        tick();
        tick();
        check("sw0_acc_st",    32'(est[2]),        32'(S_MEM_ACCESS));
        check("sw0_acc_mw",    32'(o_mem_write[2]),32'd1);
        check("sw0_acc_mr",    32'(o_mem_read[2]), 32'd0);
        check("sw0_acc_ret",   32'(o_retire[2]),   32'd1);
        check("sw0_acc_next",  32'(pst[2]),        32'(S_FETCH));
        tick();
        check("sw0_end_st",    32'(est[2]),        32'(S_FETCH));

        // illegal opcode 0x00 traps until reset
        opc[2] = 7'h00;
        tick();
        tick();
        check("trap_dec_next", 32'(pst[2]),        32'(S_TRAP));
        tick();
        for (int i = 0; i < 20; i++) begin
            check("trap_st",     32'(est[2]),        32'(S_TRAP));
            check("trap_ill",    32'(o_illegal[2]),  32'd1);
            check("trap_mr",     32'(o_mem_read[2]), 32'd0);
            check("trap_ret",    32'(o_retire[2]),   32'd0);
            tick();
        end
        rst_n[2] = 1'b0;
        #1;
        check("trap_rst_st",   32'(est[2]),        32'(S_FETCH));
        check("trap_rst_ill",  32'(o_illegal[2]),  32'd0);
        tick();
        rst_n[2] = 1'b1;
        #1;
        check("trap_rel_st",   32'(est[2]),        32'(S_FETCH));
        check("trap_rel_ill",  32'(o_illegal[2]),  32'd0);
        check("trap_rel_mr",   32'(o_mem_read[2]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
